// File: rtl/ub_port_arbiter.sv
// ub_port_arbiter
//
// Shares the single unified-buffer port between three burst requesters
// (0 = host rx load, 1 = host tx readback, 2 = compute engine). A requester
// asks for a whole burst (start address, length, direction). One burst is
// granted at a time in round-robin order. The granted burst is then issued one
// word per cycle, and the owner can stall any beat.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req / req_we        per-requester burst request and direction (1 = write)
//   req_addr / req_len  per-requester start address and length, packed by index
//   stall               per-requester "not ready": no access is issued this cycle
//   wdata               per-requester write word, packed by index
//   gnt                 one-hot, high for the whole burst
//   done                one-cycle pulse after the last access of a burst
//   rvalid / rdata      read return, one cycle after each read access
//   ub_*                unified buffer port (ub_rdata valid one cycle after a read)
//
// Build option
//   UB_COMPUTE_PRIORITY_EN  the compute requester (index NUM_REQ-1) wins every
//                           arbitration it takes part in. The other requesters
//                           share round-robin, and the pointer only moves on
//                           their grants. When this is undefined, the arbiter
//                           uses pure round-robin across all requesters.
//
// States
//   S_IDLE  | no burst owned; arbitrate among pending requests
//   S_BURST | burst owned by owner_q; issue one access per unstalled cycle

module ub_port_arbiter #(
  parameter int NUM_REQ          = 3,
  parameter int ADDRESS_SIZE     = 10,
  parameter int BUFFER_WORD_SIZE = 16,
  parameter int LEN_W            = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0]                 req_we,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0]    req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]           req_len,
  input  logic [NUM_REQ-1:0]                 stall,
  input  logic [NUM_REQ*BUFFER_WORD_SIZE-1:0] wdata,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic [NUM_REQ-1:0]                 done,
  output logic [NUM_REQ-1:0]                 rvalid,
  output logic [BUFFER_WORD_SIZE-1:0]        rdata,
  output logic                               ub_en,
  output logic                               ub_we,
  output logic [ADDRESS_SIZE-1:0]            ub_addr,
  output logic [BUFFER_WORD_SIZE-1:0]        ub_wdata,
  input  logic [BUFFER_WORD_SIZE-1:0]        ub_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Number of requesters that take part in the round-robin rotation.
`ifdef UB_COMPUTE_PRIORITY_EN
  localparam int RR_N = NUM_REQ - 1;
`else
  localparam int RR_N = NUM_REQ;
`endif

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            owner_q, owner_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic                        we_q, we_d;
  logic [ADDRESS_SIZE-1:0]     cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]            remaining_q, remaining_d;
  logic [NUM_REQ-1:0]          gnt_q, gnt_d;
  logic [NUM_REQ-1:0]          done_q, done_d;
  logic                        tag_valid_q, tag_valid_d;
  logic [IDX_W-1:0]            tag_owner_q, tag_owner_d;

  // Unpacked views of the packed per-requester buses.
  logic [ADDRESS_SIZE-1:0]     addr_arr  [NUM_REQ];
  logic [LEN_W-1:0]            len_arr   [NUM_REQ];
  logic [BUFFER_WORD_SIZE-1:0] wdata_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDRESS_SIZE +: ADDRESS_SIZE];
      len_arr[i]   = req_len[i*LEN_W +: LEN_W];
      wdata_arr[i] = wdata[i*BUFFER_WORD_SIZE +: BUFFER_WORD_SIZE];
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration: scan from ptr_q and take the first pending requester.
  // ---------------------------------------------------------------------------
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             ptr_upd;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] ptr_nxt;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    ptr_upd   = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && (int'(cand) < RR_N) && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        ptr_upd   = 1'b1;
      end
    end
`ifdef UB_COMPUTE_PRIORITY_EN
    // Compute overrides the rotation and leaves the pointer where it was.
    if (req[NUM_REQ-1]) begin
      win_found = 1'b1;
      win_idx   = IDX_W'(NUM_REQ - 1);
      ptr_upd   = 1'b0;
    end
`endif
    ptr_nxt = IDX_W'((int'(win_idx) + 1) % NUM_REQ);
  end

  // ---------------------------------------------------------------------------
  // Access issue. A dropped request aborts the burst, so the access is also
  // gated by the owner's request to avoid writing on the abort cycle.
  // ---------------------------------------------------------------------------
  logic burst;
  logic access;

  always_comb begin
    burst  = (state_q == S_BURST);
    access = burst && req[owner_q] && !stall[owner_q] && (remaining_q != '0);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    we_d        = we_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    tag_valid_d = access && !we_q;
    tag_owner_d = owner_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d        = S_BURST;
          owner_d        = win_idx;
          we_d           = req_we[win_idx];
          cur_addr_d     = addr_arr[win_idx];
          remaining_d    = len_arr[win_idx];
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          if (ptr_upd) begin
            ptr_d = ptr_nxt;
          end
        end
      end

      S_BURST: begin
        if (!req[owner_q]) begin
          // Abort: leave without a done pulse.
          state_d = S_IDLE;
          gnt_d   = '0;
        end else if (remaining_q == '0) begin
          // Zero-length burst: one empty cycle, then done.
          state_d         = S_IDLE;
          gnt_d           = '0;
          done_d[owner_q] = 1'b1;
        end else if (access) begin
          // Address wraps naturally at 2^ADDRESS_SIZE.
          cur_addr_d  = cur_addr_q + ADDRESS_SIZE'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d         = S_IDLE;
            gnt_d           = '0;
            done_d[owner_q] = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      we_q        <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      tag_valid_q <= 1'b0;
      tag_owner_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      we_q        <= we_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Port-side signals are forced to zero outside a burst. This keeps
  // the buffer port quiet in IDLE and right after reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt      = gnt_q;
    done     = done_q;
    ub_en    = access;
    ub_we    = burst && we_q;
    ub_addr  = burst ? cur_addr_q : '0;
    ub_wdata = burst ? wdata_arr[owner_q] : '0;
    rvalid   = '0;
    if (tag_valid_q) begin
      rvalid[tag_owner_q] = 1'b1;
    end
    rdata    = tag_valid_q ? ub_rdata : '0;
  end

endmodule

// File: tb/tb_ub_port_arbiter.sv
module tb_ub_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LW = 5;
  localparam int DEPTH = 1 << AW;

`ifdef UB_COMPUTE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req, req_we, stall;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*LW-1:0]  req_len;
  logic [NR*DW-1:0]  wdata;
  logic [NR-1:0]     gnt, done, rvalid;
  logic [DW-1:0]     rdata;
  logic              ub_en, ub_we;
  logic [AW-1:0]     ub_addr;
  logic [DW-1:0]     ub_wdata;
  logic [DW-1:0]     ub_rdata;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Buffer behaviour seen by the DUT, and the bench's own view of its contents.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  ub_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_len  (req_len),
    .stall    (stall),
    .wdata    (wdata),
    .gnt      (gnt),
    .done     (done),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ub_en    (ub_en),
    .ub_we    (ub_we),
    .ub_addr  (ub_addr),
    .ub_wdata (ub_wdata),
    .ub_rdata (ub_rdata)
  );

  function automatic logic [DW-1:0] preload(input int i);
    return DW'((i * 40503) ^ 23130);
  endfunction

  function automatic logic [NR-1:0] oh(input int i);
    return NR'(1 << i);
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = preload(i);
  end

  always @(posedge clk) begin
    if (ub_en) begin
      if (ub_we) mem[ub_addr] <= ub_wdata;
      else       ub_rdata     <= mem[ub_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_req(input int r, input bit we, input int addr, input int len);
    req_we[r]            = we;
    req_addr[r*AW +: AW] = AW'(addr);
    req_len[r*LW +: LW]  = LW'(len);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},      32'(gnt),      32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_rvalid"},   32'(rvalid),   32'd0);
    chk({tag, "_ub_en"},    32'(ub_en),    32'd0);
    chk({tag, "_ub_we"},    32'(ub_we),    32'd0);
    chk({tag, "_ub_addr"},  32'(ub_addr),  32'd0);
    chk({tag, "_ub_wdata"}, 32'(ub_wdata), 32'd0);
    chk({tag, "_rdata"},    32'(rdata),    32'd0);
  endtask

  // A single-requester burst, checked cycle by cycle against the timing rules:
  // grant the cycle after the request, one access per unstalled cycle, done
  // the cycle after the last access, read data one cycle after each read.
  // abort_after >= 0 drops the request (with stall held) once that many
  // accesses have been made. done_cyc returns the cycle done pulsed (-1 if none).
  task automatic do_burst(input int r, input bit we, input int addr, input int len,
                          input logic [31:0] stall_pat, input int abort_after,
                          input bit rand_data, output int done_cyc);
    int acc, prev_a;
    bit prev_rd, ending, aborted, dropping, st, exp_en;
    logic [DW-1:0] wd;
    acc = 0; prev_a = 0; prev_rd = 0; ending = 0; aborted = 0; done_cyc = -1;

    @(posedge clk); #1;
    req = '0; req[r] = 1'b1; stall = '0;
    load_req(r, we, addr, len);
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 32'd0);

    for (int c = 1; c < 200; c++) begin
      @(posedge clk); #1;
      if (ending) begin
        req[r] = 1'b0;
        stall  = '0;
        @(negedge clk);
        chk("end_gnt",  32'(gnt),   32'd0);
        chk("end_done", 32'(done),  aborted ? 32'd0 : 32'(oh(r)));
        chk("end_en",   32'(ub_en), 32'd0);
        chk("end_rvalid", 32'(rvalid), prev_rd ? 32'(oh(r)) : 32'd0);
        if (prev_rd) chk("end_rdata", 32'(rdata), 32'(ref_mem[prev_a]));
        if (!aborted) done_cyc = c;
        return;
      end
      dropping = (abort_after >= 0) && (acc == abort_after);
      st       = dropping ? 1'b1 : ((c - 1 < 32) ? stall_pat[c-1] : 1'b0);
      stall    = '0;
      stall[r] = st;
      if (dropping) req[r] = 1'b0;
      wd    = rand_data ? DW'($urandom) : DW'(16'h00A0 + acc);
      wdata = {$urandom, $urandom};
      wdata[r*DW +: DW] = wd;
      // Fields must only be sampled in IDLE, so disturb them mid-burst.
      load_req(r, 1'($urandom), int'($urandom), int'($urandom));
      @(negedge clk);
      exp_en = !st && (acc < len);
      chk("b_gnt",  32'(gnt),   32'(oh(r)));
      chk("b_done", 32'(done),  32'd0);
      chk("b_en",   32'(ub_en), 32'(exp_en));
      if (exp_en) begin
        chk("b_addr", 32'(ub_addr), 32'((addr + acc) % DEPTH));
        chk("b_we",   32'(ub_we),   32'(we));
        if (we) chk("b_wdata", 32'(ub_wdata), 32'(wd));
      end
      chk("b_rvalid", 32'(rvalid), prev_rd ? 32'(oh(r)) : 32'd0);
      if (prev_rd) chk("b_rdata", 32'(rdata), 32'(ref_mem[prev_a]));
      prev_rd = exp_en && !we;
      prev_a  = (addr + acc) % DEPTH;
      if (exp_en) begin
        if (we) ref_mem[prev_a] = wd;
        acc++;
      end
      if (dropping) begin
        aborted = 1'b1;
        ending  = 1'b1;
      end else if (len == 0 || acc == len) begin
        ending = 1'b1;
      end
    end
    chk("burst_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int dc, own, b, ph, ra;
    int ca [NR];
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_len = '0;
    stall = '0; wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = preload(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Write burst, then a read burst wrapping the top of the address space.
    do_burst(0, 1'b1, 'h010, 4, 32'd0, -1, 1'b0, dc);
    chk("wr_done_cycle", 32'(dc), 32'd5);
    do_burst(1, 1'b0, 'h3FE, 4, 32'd0, -1, 1'b1, dc);
    chk("rd_done_cycle", 32'(dc), 32'd5);
    do_burst(2, 1'b0, 'h010, 4, 32'd0, -1, 1'b1, dc);

    // Stall on the second burst cycle: accesses in 1, 3, 4; done in 5.
    do_burst(2, 1'b0, 'h123, 3, 32'b10, -1, 1'b1, dc);
    chk("stall_done_cycle", 32'(dc), 32'd5);

    // Zero length, then an abort after three accesses and a readback.
    do_burst(0, 1'b1, 'h100, 0, 32'd0, -1, 1'b1, dc);
    chk("zero_done_cycle", 32'(dc), 32'd2);
    do_burst(0, 1'b1, 'h200, 8, 32'd0, 3, 1'b1, dc);
    chk("abort_no_done", 32'(dc), 32'hFFFF_FFFF);
    do_burst(1, 1'b0, 'h200, 8, 32'd0, -1, 1'b1, dc);

    // Contention from reset: all three request two-word reads.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ca[i] = int'($urandom_range(0, DEPTH - 1));
      load_req(i, 1'b0, ca[i], 2);
    end
    req = '1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 12) req = '0;
      @(negedge clk);
      b   = (c - 1) / 3;
      ph  = (c - 1) % 3;
      own = PRIO ? NR - 1 : b % NR;
      if (ph < 2) begin
        chk("ct_gnt",  32'(gnt),     32'(oh(own)));
        chk("ct_en",   32'(ub_en),   32'd1);
        chk("ct_addr", 32'(ub_addr), 32'((ca[own] + ph) % DEPTH));
      end else begin
        chk("ct_gap_gnt", 32'(gnt),  32'd0);
        chk("ct_done",    32'(done), 32'(oh(own)));
      end
      chk("ct_rvalid", 32'(rvalid), (ph >= 1) ? 32'(oh(own)) : 32'd0);
      if (ph >= 1) chk("ct_rdata", 32'(rdata), 32'(ref_mem[(ca[own] + ph - 1) % DEPTH]));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("ct_quiet_gnt", 32'(gnt), 32'd0);

    // Reset during the fourth access of a read burst.
    ra = int'($urandom_range(0, DEPTH - 1));
    @(posedge clk); #1;
    req = '0; req[1] = 1'b1; stall = '0;
    load_req(1, 1'b0, ra, 8);
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 4) rst = 1'b1;
      @(negedge clk);
      chk("rmb_en",   32'(ub_en),   32'd1);
      chk("rmb_addr", 32'(ub_addr), 32'((ra + c - 1) % DEPTH));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req = 3'b110;
    load_req(1, 1'b0, int'($urandom), 3);
    load_req(2, 1'b0, int'($urandom), 3);
    @(negedge clk);
    check_zero("rmb");
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("rmb_regrant", 32'(gnt), PRIO ? 32'(oh(2)) : 32'(oh(1)));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmb_abort_gnt",  32'(gnt),  32'd0);
    chk("rmb_abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);

    // Randomised single-requester bursts with sparse stalls.
    for (int t = 0; t < 24; t++) begin
      do_burst(int'($urandom_range(0, NR - 1)), 1'($urandom),
               int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 31)),
               $urandom & $urandom & $urandom, -1, 1'b1, dc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ub_port_arbiter.md
# ub_port_arbiter

Arbitrates the single port of the unified buffer among three burst requesters: host load (RX FIFO → buffer writes), host readback (buffer → TX FIFO reads) and the compute engine (operand reads and result writes). Each requester asks for a whole burst (start address, length, direction). The arbiter grants one burst at a time in round-robin order, then sequences the per-word buffer accesses with per-beat stall support. It sits between the instruction controller's datapath clients and the `unified_buffer` port.

## Interface
- `NUM_REQ`, 3, number of requesters; index 0 = rx load, 1 = tx readback, 2 = compute
- `ADDRESS_SIZE`, 10, buffer address width
- `BUFFER_WORD_SIZE`, 16, buffer word width
- `LEN_W`, 5, burst length field width; maximum burst is 2^LEN_W−1 words

- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `req`  in  NUM_REQ  burst request, one bit per requester
- `req_we`  in  NUM_REQ  burst direction per requester: 1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDRESS_SIZE  start address per requester; requester i occupies slice [i*ADDRESS_SIZE +: ADDRESS_SIZE]
- `req_len`  in  NUM_REQ*LEN_W  burst length in words per requester
- `stall`  in  NUM_REQ  owner is not ready this cycle; no access is issued
- `wdata`  in  NUM_REQ*BUFFER_WORD_SIZE  write word per requester
- `gnt`  out  NUM_REQ  one-hot, held high for the whole burst
- `done`  out  NUM_REQ  one-cycle pulse when a burst completes
- `rvalid`  out  NUM_REQ  read word valid for the requester
- `rdata`  out  BUFFER_WORD_SIZE  read word; broadcast to all requesters, qualified by `rvalid`
- `ub_en`  out  1  buffer access enable
- `ub_we`  out  1  buffer write enable
- `ub_addr`  out  ADDRESS_SIZE  buffer address
- `ub_wdata`  out  BUFFER_WORD_SIZE  buffer write word
- `ub_rdata`  in  BUFFER_WORD_SIZE  buffer read word, valid one cycle after a read access

## Operation
- The FSM has two states: IDLE and BURST.
- **IDLE:**
  - If any `req` bit is set, pick a winner by round-robin starting at pointer `ptr`.
  - Latch the winner's owner index, `req_we`, `req_addr` and `req_len` into `cur_addr` and `remaining`.
  - Move to BURST and set pointer `ptr` ← (winner+1) mod NUM_REQ.
- **BURST:**
  - `gnt[owner]` is set.
  - `ub_en` = ~`stall[owner]` & (`remaining`≠0).
  - `ub_addr` = `cur_addr`; `ub_we` = latched direction; `ub_wdata` = `wdata[owner]`.
  - On each issued access: `cur_addr` increments modulo 2^ADDRESS_SIZE (0x3FF wraps to 0x000), and `remaining` decrements.
  - When `remaining` reaches 0: pulse `done[owner]`, clear `gnt` and return to IDLE on the next cycle.
- **Zero length:** a latched `req_len`=0 gives one BURST cycle with no access, then `done`. The pointer still rotates.
- **Abort:** if `req[owner]` drops during BURST, the arbiter returns to IDLE on the next cycle. No further accesses are issued and `done` does not pulse.
- **Read return:** a registered tag (valid, owner) follows every read access. `rvalid[tag]` = 1 and `rdata` = `ub_rdata` one cycle after the access, even if the FSM has already returned to IDLE.
- **Sampling:** requests arriving while another burst is active are held by the requester and seen in the next IDLE. `req_addr`, `req_len` and `req_we` are sampled only in IDLE.
- **Reset:**
  - Outputs: `gnt`, `done`, `rvalid`, `ub_en` and `ub_we` = 0; `ub_addr`, `ub_wdata` and `rdata` = 0.
  - State: FSM in IDLE, `ptr` = 0, and the read tag is cleared.
  - Reset mid-burst takes effect on the next edge; an in-flight read returns no `rvalid`.

## Timing
- A request seen in IDLE at cycle N gives `gnt` at N+1.
- With no stalls, accesses run N+1 … N+L.
- `done` pulses at N+L+1; the FSM is in IDLE at N+L+1.
- The earliest next grant is N+L+2, so there is 1 dead cycle between back-to-back bursts.
- Read latency is one cycle: `rvalid` follows at N+2 … N+L+1.
- `ub_en`, `ub_we`, `ub_addr` and `ub_wdata` are combinational from registered state and `stall`/`wdata`; there is a same-cycle stall response.
- Throughput is 1 word per cycle within a burst.

## Configuration
- **`UB_COMPUTE_PRIORITY_EN` defined:** requester NUM_REQ−1 (compute) wins every IDLE arbitration in which it requests. The other requesters share round-robin among themselves, and `ptr` only updates on their grants.
- **Not defined:** pure round-robin across all requesters.

## Test plan
- **Write burst:** `req[0]`, we=1, addr 0x010, len 4, `wdata` 0xA0..0xA3, no stall → `ub_en` for 4 cycles at 0x010–0x013 with those words; `done[0]` the following cycle.
- **Read burst:** `req[1]`, read, addr 0x3FE, len 4 → addresses 0x3FE, 0x3FF, 0x000, 0x001; four `rvalid[1]` pulses, each one cycle after its access, carrying the preloaded words.
- **Contention:** all three `req` high from reset, len 2 each → grant order 0, 1, 2, 0, …; a 1-cycle gap between `done` and the next `gnt`. With `UB_COMPUTE_PRIORITY_EN`: order is 2, 2, … while `req[2]` stays high.
- **Stall:** compute read, len 3, `stall[2]` high on the 2nd burst cycle → accesses in cycles 1, 3 and 4; `done[2]` at cycle 5.
- **Zero length and abort:** `req[0]` len 0 → no `ub_en`, `done[0]` one cycle after `gnt`. Then len 8 with `req[0]` dropped after 3 accesses → exactly 3 accesses, no `done`, FSM back in IDLE.
- **Reset mid-burst:** read burst len 8, `rst` asserted during the 4th access → next cycle all outputs 0, no `rvalid` for that access; a subsequent `req[1]` is granted first because `ptr` is 0.
